// File: rtl/imem_pkg.sv
// Shared types for the instruction fetch memory: fault codes, NOP constant, response record.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package imem_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  // Canonical RV32 NOP (addi x0, x0, 0), returned in place of faulted fetches
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Default response record for a 32-bit core with 32-bit addresses
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    fault_e      fault;
  } imem_resp_t;

endpackage

// File: rtl/imem_resp_fifo.sv
// In-order response buffer with synchronous flush and a registered empty flag.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pushes into a full buffer are ignored; the caller's credit scheme prevents them.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = imem_resp_t,
  parameter int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_nxt;

  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Payload storage; no reset needed since entries are only read when counted valid
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointers, count and empty flag; flush drops everything including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Byte-addressable instruction memory with valid/ready fetch, fault detection, flush and program-load port.
// Latency: READ_LATENCY cycles from accept to resp_valid when the response buffer is empty.
// Backpressure: credit-based; req_ready drops once in-flight + buffered reaches RESP_DEPTH, so nothing is dropped.
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int    ADDR_WIDTH   = 32,
  parameter int    DATA_WIDTH   = 32,
  parameter int    MEM_BYTES    = 2048,
  parameter int    READ_LATENCY = 1,
  parameter int    RESP_DEPTH   = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic                         flush,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_WIDTH-1:0]        resp_instr,
  output logic [ADDR_WIDTH-1:0]        resp_addr,
  output logic [1:0]                   resp_fault,
  input  logic                         prog_we,
  input  logic [$clog2(MEM_BYTES)-1:0] prog_addr,
  input  logic [7:0]                   prog_wdata
);

  localparam int NB         = DATA_WIDTH / 8;
  localparam int MA_W       = $clog2(MEM_BYTES);
  localparam int CNT_W      = $clog2(READ_LATENCY + RESP_DEPTH + 1);
  localparam int FIFO_CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_BYTES - NB);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] addr;
    fault_e                fault;
  } resp_t;

  logic [7:0]            mem [MEM_BYTES];

  logic                  accept;
  fault_e                req_fault;
  logic [MA_W-1:0]       rd_base;
  logic [DATA_WIDTH-1:0] rd_data;
  resp_t                 req_entry;

  logic [READ_LATENCY-1:0] pv;
  resp_t                   pd [READ_LATENCY];

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  resp_t                 fifo_head;

  logic                  direct_take;
  logic [CNT_W-1:0]      outstanding;
  resp_t                 resp_out;

  // Program-load byte writes; memory contents survive reset
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  // Classify the request address; misalignment wins over out-of-range
  always_comb begin
    req_fault = FAULT_NONE;
    if ((req_addr & ALIGN_MASK) != '0) begin
      req_fault = FAULT_MISALIGN;
    end else if (req_addr > LAST_ADDR) begin
      req_fault = FAULT_RANGE;
    end
  end

  // Gather NB bytes little-endian; faulted requests read from base 0 so no index leaves the array
  always_comb begin
    rd_base = (req_fault == FAULT_NONE) ? req_addr[MA_W-1:0] : '0;
    rd_data = '0;
    for (int i = 0; i < NB; i++) begin
      rd_data[8*i +: 8] = mem[rd_base + MA_W'(i)];
    end
    req_entry.instr = (req_fault == FAULT_NONE) ? rd_data : DATA_WIDTH'(RV_NOP);
    req_entry.addr  = req_addr;
    req_entry.fault = req_fault;
  end

  // Credits count everything between accept and consumer; built only from registered state
  always_comb begin
    outstanding = CNT_W'(fifo_count);
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding = outstanding + CNT_W'(pv[i]);
    end
  end

  assign req_ready = (outstanding < CNT_W'(RESP_DEPTH)) && !flush && !prog_we;
  assign accept    = req_valid && req_ready;

  // Latency pipeline: always advances, the credit limit guarantees the buffer has room
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept && !flush;
      pd[0] <= req_entry;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1] && !flush;
        pd[i] <= pd[i-1];
      end
    end
  end

  // Last stage is handed straight to the consumer when the buffer is empty, else queued behind older entries
  assign direct_take = resp_ready && fifo_empty;
  assign fifo_push   = pv[READ_LATENCY-1] && !direct_take;
  assign fifo_pop    = resp_ready && !fifo_empty;

  imem_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (resp_t),
    .CNT_W (FIFO_CNT_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (pd[READ_LATENCY-1]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Present the oldest response; outputs read zero when nothing is valid
  always_comb begin
    resp_valid = pv[READ_LATENCY-1] || !fifo_empty;
    resp_out   = '0;
    if (resp_valid) begin
      resp_out = fifo_empty ? pd[READ_LATENCY-1] : fifo_head;
    end
  end

  assign resp_instr = resp_out.instr;
  assign resp_addr  = resp_out.addr;
  assign resp_fault = resp_out.fault;

endmodule
